// File: rtl/regfile_issue_scoreboard.sv
`default_nettype none

`ifndef REG_NPOLY
`define REG_NPOLY 8
`endif

// ============================================================================
// Module      : regfile_issue_scoreboard
// Description : Issue scoreboard for the polynomial register file. Stalls an
//               instruction on RAW/WAW hazards against a per-register busy
//               vector and on a busy target FU. Accepted instructions drive the
//               register file source indices and pulse fu_start one cycle
//               later. FU completions are arbitrated round-robin onto the
//               register file write ports, one FU per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_issue_scoreboard #(
  parameter int REG_NPOLY = `REG_NPOLY,
  parameter int NFU       = 4,
  parameter int RIDX_W    = $clog2(REG_NPOLY),
  parameter int FID_W     = $clog2(NFU)
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction front-end
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RIDX_W-1:0]    in_src [4],
  input  logic [3:0]           in_src_use,
  input  logic [RIDX_W-1:0]    in_dst [2],
  input  logic [1:0]           in_dst_use,
  input  logic [FID_W-1:0]     in_fu,
  // register file read side and FU start
  output logic [RIDX_W-1:0]    src_idx [4],
  output logic [NFU-1:0]       fu_start,
  // FU completion and register file write side
  input  logic [NFU-1:0]       fu_done,
  output logic [NFU-1:0]       fu_grant,
  output logic [RIDX_W-1:0]    dest_idx [2],
  output logic [1:0]           dest_we,
  // scoreboard visibility
  output logic [REG_NPOLY-1:0] busy
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NFU-1:0]       fu_busy;
  logic [FID_W-1:0]     rr_ptr;
  logic [RIDX_W-1:0]    rec_dst [NFU][2];
  logic [1:0]           rec_use [NFU];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                 hazard;
  logic                 accept;
  logic [NFU-1:0]       req;
  logic                 grant_found;
  logic [FID_W-1:0]     grant_id;
  logic [FID_W:0]       arb_sum;
  logic [FID_W-1:0]     arb_cand;
  logic [FID_W-1:0]     next_ptr;
  logic [REG_NPOLY-1:0] busy_next;
  logic [NFU-1:0]       fu_busy_next;

  // Hazard check against the scoreboard as held at the start of the cycle
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (in_src_use[k] && busy[in_src[k]]) hazard = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (in_dst_use[k] && busy[in_dst[k]]) hazard = 1'b1;
    end
    if (fu_busy[in_fu]) hazard = 1'b1;
    // both destinations naming one register would be a self-WAW
    if ((in_dst_use == 2'b11) && (in_dst[0] == in_dst[1])) hazard = 1'b1;
  end

  assign in_ready = ~rst & ~hazard;
  assign accept   = in_valid & in_ready;

  // A done level from an idle FU is stale and never requests the write ports
  assign req = fu_done & fu_busy;

  // Round-robin search starting at the FU after the last one granted
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    arb_sum     = '0;
    arb_cand    = '0;
    for (int i = 0; i < NFU; i++) begin
      arb_sum = {1'b0, rr_ptr} + (FID_W+1)'(i);
      if (arb_sum >= (FID_W+1)'(NFU)) arb_sum = arb_sum - (FID_W+1)'(NFU);
      arb_cand = arb_sum[FID_W-1:0];
      if (!grant_found && req[arb_cand]) begin
        grant_found = 1'b1;
        grant_id    = arb_cand;
      end
    end
  end

  // Pointer advance wraps explicitly so NFU need not be a power of two
  always_comb begin
    if (grant_id == FID_W'(NFU - 1)) next_ptr = '0;
    else                             next_ptr = grant_id + FID_W'(1);
  end

  // Write-port drive from the granted FU's destination record
  always_comb begin
    fu_grant    = '0;
    dest_we     = 2'b00;
    dest_idx[0] = rec_dst[grant_id][0];
    dest_idx[1] = rec_dst[grant_id][1];
    if (grant_found && !rst) begin
      fu_grant = NFU'(1) << grant_id;
      dest_we  = rec_use[grant_id];
    end
  end

  // Next scoreboard: writeback clears first, then issue sets (never the same bit)
  always_comb begin
    busy_next    = busy;
    fu_busy_next = fu_busy;
    if (grant_found) begin
      for (int k = 0; k < 2; k++) begin
        if (rec_use[grant_id][k]) busy_next[rec_dst[grant_id][k]] = 1'b0;
      end
      fu_busy_next[grant_id] = 1'b0;
    end
    if (accept) begin
      for (int k = 0; k < 2; k++) begin
        if (in_dst_use[k]) busy_next[in_dst[k]] = 1'b1;
      end
      fu_busy_next[in_fu] = 1'b1;
    end
  end

  // Scoreboard, arbitration pointer and FU start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      fu_busy  <= '0;
      rr_ptr   <= '0;
      fu_start <= '0;
    end else begin
      busy     <= busy_next;
      fu_busy  <= fu_busy_next;
      if (grant_found) rr_ptr <= next_ptr;
      fu_start <= accept ? (NFU'(1) << in_fu) : '0;
    end
  end

  // Source indices are registered so the FU sees operands in its start cycle
  generate
    for (genvar k = 0; k < 4; k++) begin : g_src
      always_ff @(posedge clk) begin
        if (rst)         src_idx[k] <= '0;
        else if (accept) src_idx[k] <= in_src[k];
      end
    end
  endgenerate

  // Per-FU destination record captured at issue, consumed at writeback
  generate
    for (genvar f = 0; f < NFU; f++) begin : g_rec
      always_ff @(posedge clk) begin
        if (rst) begin
          rec_use[f]    <= 2'b00;
          rec_dst[f][0] <= '0;
          rec_dst[f][1] <= '0;
        end else if (accept && (in_fu == FID_W'(f))) begin
          rec_use[f]    <= in_dst_use;
          rec_dst[f][0] <= in_dst[0];
          rec_dst[f][1] <= in_dst[1];
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_issue_scoreboard.sv
`default_nettype none

// ============================================================================
// Module      : tb_regfile_issue_scoreboard
// Description : Directed self-checking bench for regfile_issue_scoreboard.
//               Expected issues and grants are queued when stimulus is driven
//               and compared when the design responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_src [4];
  logic [3:0] in_src_use;
  logic [2:0] in_dst [2];
  logic [1:0] in_dst_use;
  logic [1:0] in_fu;
  logic [2:0] src_idx [4];
  logic [3:0] fu_start;
  logic [3:0] fu_done;
  logic [3:0] fu_grant;
  logic [2:0] dest_idx [2];
  logic [1:0] dest_we;
  logic [7:0] busy;

  regfile_issue_scoreboard #(.REG_NPOLY(8), .NFU(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src     (in_src),
    .in_src_use (in_src_use),
    .in_dst     (in_dst),
    .in_dst_use (in_dst_use),
    .in_fu      (in_fu),
    .src_idx    (src_idx),
    .fu_start   (fu_start),
    .fu_done    (fu_done),
    .fu_grant   (fu_grant),
    .dest_idx   (dest_idx),
    .dest_we    (dest_we),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  start;
    logic [11:0] srcs;
  } iss_t;

  iss_t       iq [$];
  int         gq [$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] busy_m;
  logic [2:0] rd_m [4][2];
  logic [1:0] ru_m [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction for one cycle; s packs src k at [3k+2:3k], d packs dst k likewise
  task automatic offer(input int fu, input logic [11:0] s, input logic [3:0] su,
                       input logic [5:0] d, input logic [1:0] du,
                       input logic er, input string tag);
    iss_t e;
    in_valid   = 1'b1;
    in_fu      = fu[1:0];
    in_src_use = su;
    in_dst_use = du;
    for (int k = 0; k < 4; k++) in_src[k] = s[k*3 +: 3];
    for (int k = 0; k < 2; k++) in_dst[k] = d[k*3 +: 3];
    #1;
    chk({tag, "_ready"}, in_ready, er);
    if (er) begin
      iq.push_back('{start: 4'b0001 << fu, srcs: s});
      ru_m[fu] = du;
      for (int k = 0; k < 2; k++) begin
        rd_m[fu][k] = d[k*3 +: 3];
        if (du[k]) busy_m[d[k*3 +: 3]] = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_src_use = 4'b0000;
    in_dst_use = 2'b00;
    if (iq.size() > 0) begin
      e = iq.pop_front();
      chk({tag, "_start"}, fu_start, e.start);
      chk({tag, "_src"}, {src_idx[3], src_idx[2], src_idx[1], src_idx[0]}, e.srcs);
    end else begin
      chk({tag, "_nostart"}, fu_start, 4'b0000);
    end
    chk({tag, "_busy"}, busy, busy_m);
  endtask

  // One writeback cycle; the expected grant (-1 = none) is taken from the queue
  task automatic wb(input logic [3:0] done, input logic er, input string tag);
    int f;
    fu_done = done;
    #1;
    chk({tag, "_ready"}, in_ready, er);
    f = (gq.size() > 0) ? gq.pop_front() : -1;
    if (f < 0) begin
      chk({tag, "_grant"}, fu_grant, 4'b0000);
      chk({tag, "_we"}, dest_we, 2'b00);
    end else begin
      chk({tag, "_grant"}, fu_grant, 4'b0001 << f);
      chk({tag, "_we"}, dest_we, ru_m[f]);
      if (ru_m[f][0]) chk({tag, "_idx0"}, dest_idx[0], rd_m[f][0]);
      if (ru_m[f][1]) chk({tag, "_idx1"}, dest_idx[1], rd_m[f][1]);
    end
    @(posedge clk); #1;
    if (f >= 0) begin
      for (int k = 0; k < 2; k++) if (ru_m[f][k]) busy_m[rd_m[f][k]] = 1'b0;
    end
    chk({tag, "_nostart"}, fu_start, 4'b0000);
    chk({tag, "_busy"}, busy, busy_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_src_use = 4'b0000;
    in_dst_use = 2'b00;
    in_fu      = 2'd0;
    fu_done    = 4'b0000;
    busy_m     = 8'h00;
    for (int k = 0; k < 4; k++) in_src[k] = 3'd0;
    for (int k = 0; k < 2; k++) in_dst[k] = 3'd0;
    for (int f = 0; f < 4; f++) begin
      ru_m[f] = 2'b00;
      rd_m[f][0] = 3'd0;
      rd_m[f][1] = 3'd0;
    end

    // power-on reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("por_busy", busy, 8'h00);
    chk("por_start", fu_start, 4'b0000);
    chk("por_grant", fu_grant, 4'b0000);
    chk("por_we", dest_we, 2'b00);
    chk("por_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // basic issue: src{1,2} dst{3,4} on fu0
    offer(0, {3'd0, 3'd0, 3'd2, 3'd1}, 4'b0011, {3'd4, 3'd3}, 2'b11, 1'b1, "issue0");

    // RAW on register 3: stalled in the grant cycle, accepted the cycle after
    in_valid   = 1'b1;
    in_fu      = 2'd1;
    in_src[0]  = 3'd3;
    in_src_use = 4'b0001;
    in_dst[0]  = 3'd6;
    in_dst_use = 2'b01;
    gq.push_back(0);
    wb(4'b0001, 1'b0, "raw_grant");
    fu_done = 4'b0000;
    offer(1, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, {3'd0, 3'd6}, 2'b01, 1'b1, "raw_issue");

    // self-WAW stalls on every cycle it is offered; WAW on busy register 6
    offer(2, 12'd0, 4'b0000, {3'd5, 3'd5}, 2'b11, 1'b0, "selfwaw_a");
    offer(2, 12'd0, 4'b0000, {3'd5, 3'd5}, 2'b11, 1'b0, "selfwaw_b");
    offer(2, 12'd0, 4'b0000, {3'd0, 3'd6}, 2'b01, 1'b0, "waw");

    // structural: fu2 busy blocks a second op; done from idle fu3 is ignored
    offer(2, {3'd0, 3'd0, 3'd0, 3'd7}, 4'b0001, {3'd0, 3'd5}, 2'b01, 1'b1, "fu2_issue");
    offer(2, 12'd0, 4'b0000, {3'd0, 3'd2}, 2'b01, 1'b0, "fu2_busy");
    gq.push_back(-1);
    wb(4'b1000, 1'b0, "idle_done");
    gq.push_back(2);
    wb(4'b0100, 1'b0, "fu2_grant");
    fu_done = 4'b0000;

    // reset mid-traffic with fu1 still in flight
    rst     = 1'b1;
    fu_done = 4'b0010;
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_grant", fu_grant, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    busy_m = 8'h00;
    for (int f = 0; f < 4; f++) ru_m[f] = 2'b00;
    #1;
    chk("rst_busy", busy, 8'h00);
    chk("rst_grant_after", fu_grant, 4'b0000);
    chk("rst_we_after", dest_we, 2'b00);
    chk("rst_ready_after", in_ready, 1'b1);
    chk("rst_start_after", fu_start, 4'b0000);
    chk("rst_src_after", src_idx[0], 3'd0);
    fu_done = 4'b0000;
    @(posedge clk); #1;

    // round-robin: all four FUs busy, done held on all of them
    offer(0, 12'd0, 4'b0000, {3'd1, 3'd0}, 2'b11, 1'b1, "rr_issue0");
    offer(1, 12'd0, 4'b0000, {3'd0, 3'd2}, 2'b01, 1'b1, "rr_issue1");
    offer(2, 12'd0, 4'b0000, {3'd0, 3'd0}, 2'b00, 1'b1, "rr_issue2");
    offer(3, 12'd0, 4'b0000, {3'd4, 3'd3}, 2'b11, 1'b1, "rr_issue3");
    gq.push_back(0);
    gq.push_back(1);
    gq.push_back(2);
    gq.push_back(3);
    gq.push_back(-1);
    wb(4'b1111, 1'b0, "rr_g0");
    wb(4'b1111, 1'b0, "rr_g1");
    wb(4'b1111, 1'b0, "rr_g2");
    wb(4'b1111, 1'b0, "rr_g3");
    wb(4'b1111, 1'b1, "rr_none");
    fu_done = 4'b0000;
    chk("final_busy", busy, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
